// File: rtl/vga_timing_gen.sv
// VGA display timing generator: pixel divider, column/row counters and registered sync/blank decode.
// Optional macro VGA_TIMING_ALIGN_EN adds one register stage to h_sync, v_sync, video_on and frame_start.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pix_col,
  output logic [9:0] pix_row,
  output logic       h_sync,
  output logic       v_sync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             von_q, von_d;
  logic             fstart_q, fstart_d;
  logic             tick;

  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    col_d     = col_q;
    row_d     = row_q;
    fstart_d  = 1'b0;
    if (tick) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        if (row_q == V_LAST) begin
          row_d    = '0;
          fstart_d = 1'b1;
        end else begin
          row_d = row_q + 10'd1;
        end
      end else begin
        col_d = col_q + 10'd1;
      end
    end
    // Decode from next-state counters so outputs land on the same edge as the counters.
    hsync_d = ((col_d >= HS_FIRST) && (col_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = ((row_d >= VS_FIRST) && (row_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    von_d   = (col_d < H_VIS) && (row_d < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      hsync_q   <= ~SYNC_ON;
      vsync_q   <= ~SYNC_ON;
      von_q     <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      von_q     <= von_d;
      fstart_q  <= fstart_d;
    end
  end

  assign pix_col  = col_q;
  assign pix_row  = row_q;
  assign pix_tick = tick;

`ifdef VGA_TIMING_ALIGN_EN
  // Extra stage matches colour generators that register once off pix_row/pix_col.
  logic hsync_al_q, vsync_al_q, von_al_q, fstart_al_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_al_q  <= ~SYNC_ON;
      vsync_al_q  <= ~SYNC_ON;
      von_al_q    <= 1'b0;
      fstart_al_q <= 1'b0;
    end else begin
      hsync_al_q  <= hsync_q;
      vsync_al_q  <= vsync_q;
      von_al_q    <= von_q;
      fstart_al_q <= fstart_q;
    end
  end

  assign h_sync      = hsync_al_q;
  assign v_sync      = vsync_al_q;
  assign video_on    = von_al_q;
  assign frame_start = fstart_al_q;
`else
  assign h_sync      = hsync_q;
  assign v_sync      = vsync_q;
  assign video_on    = von_q;
  assign frame_start = fstart_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 CLK_DIV=4 instance and a
// small-geometry CLK_DIV=1, active-high-sync instance for frame-level behaviour.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_ALIGN_EN
  localparam int ALIGN = 1;
`else
  localparam int ALIGN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic [9:0] col0, row0, col1, row1;
  logic       hs0, vs0, von0, tick0, fs0;
  logic       hs1, vs1, von1, tick1, fs1;

  vga_timing_gen dut0 (
    .clk(clk), .reset(rst0), .pix_col(col0), .pix_row(row0), .h_sync(hs0),
    .v_sync(vs0), .video_on(von0), .pix_tick(tick0), .frame_start(fs0)
  );

  // Small frame: H_TOTAL=15, V_TOTAL=8, frame = 120 clk.
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
  ) dut1 (
    .clk(clk), .reset(rst1), .pix_col(col1), .pix_row(row1), .h_sync(hs1),
    .v_sync(vs1), .video_on(von1), .pix_tick(tick1), .frame_start(fs1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         k;
    logic [9:0] col;
    logic [9:0] row;
    logic       tick;
    logic       hs;
    logic       von;
  } vec_t;

  vec_t tab [14];

  task automatic set_vec(input int i, input int k, input int c, input int r,
                         input logic t, input logic h, input logic v);
    tab[i].k   = k;
    tab[i].col = 10'(c);
    tab[i].row = 10'(r);
    tab[i].tick = t;
    tab[i].hs  = h;
    tab[i].von = v;
  endtask

  initial begin
    int fs_first, fs_second, fs_cnt, vs_cnt;
    int j, c, r;
    logic ehs, evs, evon, efs;

    // k = edges after reset release; col advances every 4th edge.
    set_vec(0,     0,   0, 0, 0, 1, 0);
    set_vec(1,     1,   0, 0, 0, 1, 1);
    set_vec(2,     3,   0, 0, 1, 1, 1);
    set_vec(3,     4,   1, 0, 0, 1, 1);
    set_vec(4,  2559, 639, 0, 1, 1, 1);
    set_vec(5,  2560, 640, 0, 0, 1, 0);
    set_vec(6,  2623, 655, 0, 1, 1, 0);
    set_vec(7,  2624, 656, 0, 0, 0, 0);
    set_vec(8,  3007, 751, 0, 1, 0, 0);
    set_vec(9,  3008, 752, 0, 0, 1, 0);
    set_vec(10, 3199, 799, 0, 1, 1, 0);
    set_vec(11, 3200,   0, 1, 0, 1, 1);
    set_vec(12, 5823, 655, 1, 1, 1, 0);
    set_vec(13, 5824, 656, 1, 0, 0, 0);

    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;
    repeat (5000) @(posedge clk);
    #1;
    chk("midframe_col", col0, 450);
    chk("midframe_row", row0, 1);

    // Reset mid-frame must take effect on the first reset edge.
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_col", col0, 0);
    chk("rst_row", row0, 0);
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_von", von0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_tick", tick0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k <= 5830; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 0) rst0 = 1'b0;
      foreach (tab[i]) begin
        if (tab[i].k == k) begin
          chk($sformatf("col_k%0d", k), col0, tab[i].col);
          chk($sformatf("row_k%0d", k), row0, tab[i].row);
          chk($sformatf("tick_k%0d", k), tick0, tab[i].tick);
        end
        if (tab[i].k + ALIGN == k) begin
          chk($sformatf("hs_k%0d", tab[i].k), hs0, tab[i].hs);
          chk($sformatf("von_k%0d", tab[i].k), von0, tab[i].von);
          chk($sformatf("vs_k%0d", tab[i].k), vs0, 1);
          chk($sformatf("fs_k%0d", tab[i].k), fs0, 0);
        end
      end
    end

    // CLK_DIV=1 instance: col = k mod 15, row = (k/15) mod 8.
    #1;
    chk("s_rst_col", col1, 0);
    chk("s_rst_row", row1, 0);
    chk("s_rst_hs", hs1, 0);
    chk("s_rst_von", von1, 0);
    rst1 = 1'b0;
    fs_first = -1;
    fs_second = -1;
    fs_cnt = 0;
    vs_cnt = 0;
    for (int k = 1; k <= 250; k++) begin
      @(posedge clk);
      #1;
      chk("s_col", col1, k % 15);
      chk("s_row", row1, (k / 15) % 8);
      chk("s_tick", tick1, 1);
      j = k - ALIGN;
      if (j <= 0) begin
        ehs = 1'b0; evs = 1'b0; evon = 1'b0; efs = 1'b0;
      end else begin
        c = j % 15;
        r = (j / 15) % 8;
        ehs  = (c >= 10) && (c <= 12);
        evs  = (r >= 5) && (r <= 6);
        evon = (c < 8) && (r < 4);
        efs  = (c == 0) && (r == 0);
      end
      chk("s_hs", hs1, ehs);
      chk("s_vs", vs1, evs);
      chk("s_von", von1, evon);
      chk("s_fs", fs1, efs);
      if (fs1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
      if (k > ALIGN && k <= 120 + ALIGN && vs1) vs_cnt++;
    end
    chk("s_fs_count", fs_cnt, 2);
    chk("s_fs_first", fs_first, 120 + ALIGN);
    chk("s_fs_period", fs_second - fs_first, 120);
    chk("s_vs_width", vs_cnt, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
